// File: rtl/shift_ctrl_if.sv
// Command/datapath bundle between a requester, the 4-bit shift register and shift_ctrl.
// The controller takes the slave view; the requester/datapath side takes the master view.
interface shift_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             req;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [3:0]       data_in;
  logic             ser_in;
  logic [3:0]       q;
  logic [1:0]       mode;
  logic [3:0]       d_out;
  logic             s_out;
  logic             busy;
  logic             ack;
  logic [CNT_W-1:0] remain;

  modport master (
    output req, op, count, data_in, ser_in, q,
    input  mode, d_out, s_out, busy, ack, remain
  );

  modport slave (
    input  req, op, count, data_in, ser_in, q,
    output mode, d_out, s_out, busy, ack, remain
  );
endinterface

// File: rtl/shift_ctrl.sv
// Sequencer for the 4-bit SET/RESET shift register: accepts one load/shift/rotate
// command at a time and drives MODE/D_OUT/S_OUT for the required number of cycles.
module shift_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic     CLK,
  input  logic     RESET,
  shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROR  = 2'b11
  } op_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_t           state, state_nx;
  op_t              op_q, op_nx;
  logic [1:0]       mode_q, mode_nx;
  logic [3:0]       d_out_q, d_out_nx;
  logic             ser_q, ser_nx;
  logic             busy_q, busy_nx;
  logic             ack_q, ack_nx;
  logic [CNT_W-1:0] remain_q, remain_nx;
  logic             accept;

  // REQ is only looked at in IDLE; anything arriving while busy is dropped.
  assign accept = (state == IDLE) && bus.req;

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      op_q     <= OP_LOAD;
      mode_q   <= MODE_HOLD;
      d_out_q  <= '0;
      ser_q    <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      remain_q <= '0;
    end else begin
      state    <= state_nx;
      op_q     <= op_nx;
      mode_q   <= mode_nx;
      d_out_q  <= d_out_nx;
      ser_q    <= ser_nx;
      busy_q   <= busy_nx;
      ack_q    <= ack_nx;
      remain_q <= remain_nx;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (op_t'(bus.op) == OP_LOAD)  state_nx = LOAD;
          else if (bus.count != '0)      state_nx = SHIFT;
          else                           state_nx = DONE;
        end
      end
      LOAD:    state_nx = DONE;
      SHIFT:   if (remain_q <= CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered, so they
  // line up with that state on the cycle after the edge.
  always_comb begin
    op_nx     = op_q;
    d_out_nx  = d_out_q;
    ser_nx    = ser_q;
    mode_nx   = MODE_HOLD;
    remain_nx = '0;
    busy_nx   = (state_nx != IDLE);
    ack_nx    = (state_nx == DONE);

    if (accept) begin
      op_nx  = op_t'(bus.op);
      ser_nx = (op_t'(bus.op) == OP_SHL || op_t'(bus.op) == OP_SHR) ? bus.ser_in : 1'b0;
      if (op_t'(bus.op) == OP_LOAD) d_out_nx = bus.data_in;
    end

    case (state_nx)
      LOAD:  mode_nx = MODE_LOAD;
      SHIFT: begin
        mode_nx   = (op_nx == OP_SHL) ? MODE_SHL : MODE_SHR;
        remain_nx = accept ? bus.count : remain_q - CNT_W'(1);
      end
      default: mode_nx = MODE_HOLD;
    endcase
  end

  assign bus.mode   = mode_q;
  assign bus.d_out  = d_out_q;
  assign bus.busy   = busy_q;
  assign bus.ack    = ack_q;
  assign bus.remain = remain_q;
  // Rotate feeds Q[0] back combinationally so the bit leaving on the right re-enters at Q[3].
  assign bus.s_out  = (state == SHIFT && op_q == OP_ROR) ? bus.q[0] : ser_q;

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencer for the 4-bit shifting register built from the team's asynchronous SET/RESET flip-flops. It accepts one command at a time from a requester over a REQ/ACK handshake and drives the register's mode select and serial input for the required number of clock cycles. It then reports completion. The controller holds no datapath bits itself; it reads the register's Q outputs only to implement rotate.

## Interface
- CNT_W, default 3: width of the shift-count field; a maximum of 2^CNT_W−1 shifts per command.
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  1  command request; sampled only in IDLE.
- OP  in  2  command: 00 parallel load, 01 shift left, 10 shift right, 11 rotate right.
- COUNT  in  CNT_W  number of shift/rotate cycles; ignored for load.
- DATA_IN  in  4  parallel load value; ignored for shifts.
- SER_IN  in  1  serial bit to insert during shift left/right.
- Q  in  4  current register contents from datapath (Q[0] = LSB).
- MODE  out  2  to datapath: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- D_OUT  out  4  parallel load value presented to the datapath.
- S_OUT  out  1  serial input presented to the datapath.
- BUSY  out  1  high while a command is in progress, DONE included.
- ACK  out  1  one-cycle completion pulse.
- REMAIN  out  CNT_W  shifts still to perform.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- Reset, asynchronous on RESET=0: the state goes to IDLE and all outputs go to 0. MODE=00 (hold), D_OUT=0, S_OUT=0, BUSY=0, ACK=0, REMAIN=0. Reset does not touch the datapath flip-flops.
- IDLE with REQ=1 at an edge: the controller latches OP, COUNT, DATA_IN and SER_IN and sets BUSY=1.
  - OP=00: next state is LOAD. D_OUT=latched DATA_IN, MODE=11.
  - OP≠00 with COUNT>0: next state is SHIFT. REMAIN=COUNT, MODE=01 or 10; rotate uses 10.
  - OP≠00 with COUNT=0: next state is DONE directly. MODE stays 00.
- LOAD: lasts exactly one cycle, then DONE.
- SHIFT: MODE stays active. REMAIN decrements each edge.
  - When REMAIN=1 at an edge, the next state is DONE and REMAIN becomes 0.
- S_OUT:
  - Shift left/right: the latched SER_IN, held constant for the whole command.
  - Rotate: combinationally equal to Q[0] while in SHIFT, giving a right rotate with Q[0] entering Q[3].
- DONE: MODE=00, ACK=1, BUSY=1 for one cycle, then IDLE. BUSY and ACK fall together.
- REQ while BUSY=1 is ignored. It is not queued.
- REQ held high continuously: a new command is accepted on the first edge in IDLE, i.e. every command costs at least one idle cycle.
- OP, COUNT, DATA_IN and SER_IN may change freely after acceptance; only the latched copies are used.

## Timing
- All outputs are registered except S_OUT in rotate mode.
- Latency, counted from the accepting edge to ACK high:
  - Load: 2 cycles (1 LOAD + DONE).
  - Shift of N>0: N+1 cycles, with exactly N edges where MODE≠00.
  - COUNT=0: 1 cycle.
- Command throughput: one accepted command per (latency+1) cycles.
- The datapath samples MODE, D_OUT and S_OUT on the same CLK edge that advances the controller. Each cycle with MODE≠00 therefore produces exactly one register update.
- RESET asserted mid-command: MODE returns to 00 immediately with no further shifts. No ACK is issued. The register keeps its partially shifted value.
- RESET release: the first accepting edge is the first rising CLK with RESET=1 and REQ=1.

## Test plan
- Load: from IDLE, REQ=1, OP=00, DATA_IN=1011. MODE=11 for one cycle, then Q=1011. ACK pulses 2 cycles after acceptance. BUSY is high 2 cycles.
- Shift left: Q=0001, OP=01, COUNT=3, SER_IN=0. Exactly 3 MODE=01 cycles, Q=1000. REMAIN goes 3→2→1→0. ACK follows the last shift.
- Rotate: Q=1001, OP=11, COUNT=5. Final Q=1100 (rotate-right by 5 ≡ by 1). S_OUT tracks Q[0] each cycle.
- Zero count and overlap: OP=10, COUNT=0. ACK on the next cycle with no MODE≠00 cycle. A second REQ during BUSY is ignored; REQ held high is re-accepted after one IDLE cycle.
- Reset mid-shift: OP=10, COUNT=7, RESET low after 2 shifts. MODE=00, BUSY=0 and REMAIN=0 immediately. Q shows exactly 2 shifts. No ACK.
- Max count with CNT_W=3: COUNT=7, shift right, SER_IN=1, Q=0000. Q=1111 after 7 shifts. Latency is 8 cycles.
